// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants; also consumed by decode.
package inst_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    // One prefetched instruction together with the address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // MIPS opcodes used by the lab ROM program
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Force an address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-stage bus: control inputs, ROM port and the decode handshake.
interface inst_fetch_ctrl_if;

    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        busy;
    logic [31:0] fetch_cnt;

    // Fetch controller side
    modport master (
        input  start, halt_req, redirect_valid, redirect_pc, rom_inst, id_ready,
        output rom_addr, if_valid, if_inst, if_pc, busy, fetch_cnt
    );

    // Environment side (control, ROM and decode)
    modport slave (
        output start, halt_req, redirect_valid, redirect_pc, rom_inst, id_ready,
        input  rom_addr, if_valid, if_inst, if_pc, busy, fetch_cnt
    );

endinterface

// File: rtl/inst_fetch_ctrl_fifo.sv
// Prefetch FIFO: DEPTH entries (power of two), flush wins over push/pop.
module fetch_fifo
    import inst_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  fetch_entry_t wr_data_i,
    output logic         full_o,
    output logic         empty_o,
    output fetch_entry_t head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: PC, start/halt FSM, redirect flush, prefetch FIFO.
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input logic               clk,
    input logic               rst_n,
    inst_fetch_ctrl_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fetch_cnt_q, fetch_cnt_d;
    logic         push;
    logic         pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;

    // Handshake decode; a full FIFO can still accept when the head leaves
    assign pop      = !fifo_empty && bus.id_ready;
    assign push     = (state_q == RUN) && !bus.redirect_valid && !bus.halt_req
                      && (!fifo_full || pop);
    assign wr_entry = '{pc: pc_q, inst: bus.rom_inst};

    // Next state, PC and fetch counter; redirect overrides sequential fetch
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (bus.halt_req) state_d = HALT;
            HALT:    if (bus.start && !bus.halt_req) state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (bus.redirect_valid) begin
            pc_d = word_align(bus.redirect_pc);
        end else if (push) begin
            pc_d        = pc_q + 32'd4;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (push),
        .pop_i     (pop),
        .flush_i   (bus.redirect_valid),
        .wr_data_i (wr_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (head)
    );

    assign bus.rom_addr  = pc_q;
    assign bus.if_valid  = !fifo_empty;
    assign bus.if_inst   = head.inst;
    assign bus.if_pc     = head.pc;
    assign bus.busy      = (state_q == RUN) || !fifo_empty;
    assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: queue-level reference model plus directed scenarios.
module tb_inst_fetch_ctrl;
    import inst_fetch_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inst_fetch_ctrl_if bus();

    logic [31:0] rom [256];
    assign bus.rom_inst = rom[bus.rom_addr[9:2]];

    inst_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst} and the architectural PC/count/state
    fetch_entry_t mq [$];
    logic [31:0]  m_pc    = 32'h0;
    logic [31:0]  m_cnt   = 32'h0;
    int           m_state = M_IDLE;
    bit           m_pop;
    bit           m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc    = 32'h0;
            m_cnt   = 32'h0;
            m_state = M_IDLE;
        end else begin
            m_pop  = (mq.size() > 0) && bus.id_ready;
            m_push = (m_state == M_RUN) && !bus.redirect_valid && !bus.halt_req
                     && ((mq.size() < DEPTH) || m_pop);
            if (bus.redirect_valid) begin
                mq.delete();
                m_pc = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back('{pc: m_pc, inst: rom[m_pc[9:2]]});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
            end
            if (m_state == M_IDLE && bus.start) m_state = M_RUN;
            else if (m_state == M_RUN && bus.halt_req) m_state = M_HALT;
            else if (m_state == M_HALT && bus.start && !bus.halt_req) m_state = M_RUN;
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_if_valid", 32'(bus.if_valid), 32'(mq.size() != 0));
        chk("m_rom_addr", bus.rom_addr, m_pc);
        chk("m_busy", 32'(bus.busy), 32'((m_state == M_RUN) || (mq.size() != 0)));
        chk("m_fetch_cnt", bus.fetch_cnt, m_cnt);
        if (mq.size() != 0) begin
            chk("m_if_pc", bus.if_pc, mq[0].pc);
            chk("m_if_inst", bus.if_inst, mq[0].inst);
        end
    end

    // Log of what decode actually accepted
    fetch_entry_t dlv [$];
    always @(posedge clk) begin
        if (rst_n && bus.if_valid === 1'b1 && bus.id_ready === 1'b1)
            dlv.push_back('{pc: bus.if_pc, inst: bus.if_inst});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.start          = 1'b0;
        bus.halt_req       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        dlv.delete();
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    logic [31:0] addr_v;

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 | 32'(i);
        rom[0]   = 32'h0000_0000;
        rom[1]   = 32'h0043_0820;   // add $1,$2,$3
        rom[2]   = 32'h0023_2022;   // sub $4,$1,$3
        rom[3]   = 32'h0081_2824;   // and $5,$4,$1
        rom[4]   = 32'h3426_800A;   // ori $6,$1,0x800a
        rom[255] = 32'h0800_0000;   // j 0

        // Reset values
        do_reset();
        chk("rst_rom_addr", bus.rom_addr, 32'h0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_fetch_cnt", bus.fetch_cnt, 32'h0);
        chk("rst_if_inst", bus.if_inst, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);

        // 1: streaming with decode always ready
        bus.id_ready = 1'b1;
        pulse_start();
        chk("t1_latency_valid", 32'(bus.if_valid), 32'h0);
        step();
        chk("t1_pc0", bus.if_pc, 32'h0);
        chk("t1_inst0", bus.if_inst, 32'h0);
        step();
        chk("t1_pc1", bus.if_pc, 32'h4);
        chk("t1_inst1", bus.if_inst, 32'h0043_0820);
        step();
        chk("t1_pc2", bus.if_pc, 32'h8);
        chk("t1_inst2", bus.if_inst, 32'h0023_2022);
        chk("t1_fetch_cnt", bus.fetch_cnt, 32'd3);

        // 2: decode stalled fills exactly DEPTH, then drains in order
        do_reset();
        pulse_start();
        repeat (4) step();
        chk("t2_rom_addr_stall", bus.rom_addr, 32'h8);
        chk("t2_fetch_cnt", bus.fetch_cnt, 32'd2);
        chk("t2_head_pc", bus.if_pc, 32'h0);
        bus.id_ready = 1'b1;
        repeat (3) step();
        chk("t2_dlv_count", 32'(dlv.size()), 32'd3);
        if (dlv.size() >= 3) begin
            chk("t2_dlv0", dlv[0].pc, 32'h0);
            chk("t2_dlv1", dlv[1].pc, 32'h4);
            chk("t2_dlv2", dlv[2].pc, 32'h8);
        end

        // 3: redirect while full flushes and reloads aligned PC
        bus.id_ready = 1'b0;
        step();
        chk("t3_full_rom_addr", bus.rom_addr, 32'h14);
        chk("t3_full_head", bus.if_pc, 32'hC);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0013;
        step();
        bus.redirect_valid = 1'b0;
        chk("t3_flush_valid", 32'(bus.if_valid), 32'h0);
        chk("t3_redir_addr", bus.rom_addr, 32'h10);
        step();
        chk("t3_new_valid", 32'(bus.if_valid), 32'h1);
        chk("t3_new_pc", bus.if_pc, 32'h10);
        chk("t3_new_inst", bus.if_inst, 32'h3426_800A);

        // 4: halt at pc 0x0C, drain, resume from 0x0C
        do_reset();
        bus.id_ready = 1'b1;
        pulse_start();
        repeat (3) step();
        chk("t4_pc_before_halt", bus.rom_addr, 32'hC);
        bus.halt_req = 1'b1;
        bus.id_ready = 1'b0;
        step();
        bus.halt_req = 1'b0;
        chk("t4_halt_busy", 32'(bus.busy), 32'h1);
        chk("t4_halt_head", bus.if_pc, 32'h8);
        step();
        chk("t4_halt_hold_addr", bus.rom_addr, 32'hC);
        chk("t4_halt_cnt", bus.fetch_cnt, 32'd3);
        bus.id_ready = 1'b1;
        step();
        chk("t4_drained_valid", 32'(bus.if_valid), 32'h0);
        chk("t4_drained_busy", 32'(bus.busy), 32'h0);
        pulse_start();
        chk("t4_resume_busy", 32'(bus.busy), 32'h1);
        step();
        chk("t4_resume_pc", bus.if_pc, 32'hC);
        chk("t4_resume_inst", bus.if_inst, 32'h0081_2824);

        // 5: PC wraps from the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        addr_v = bus.rom_addr;
        chk("t5_addr_top", addr_v, 32'hFFFF_FFFC);
        chk("t5_idx_top", 32'(addr_v[9:2]), 32'hFF);
        step();
        addr_v = bus.rom_addr;
        chk("t5_pc_top", bus.if_pc, 32'hFFFF_FFFC);
        chk("t5_inst_top", bus.if_inst, 32'h0800_0000);
        chk("t5_idx_wrap", 32'(addr_v[9:2]), 32'h00);
        step();
        chk("t5_pc_wrap", bus.if_pc, 32'h0);
        chk("t5_cnt", bus.fetch_cnt, 32'd6);

        // 6: asynchronous reset mid-run with a full FIFO
        do_reset();
        pulse_start();
        repeat (2) step();
        chk("t6_pre_cnt", bus.fetch_cnt, 32'd2);
        chk("t6_pre_valid", 32'(bus.if_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.if_valid), 32'h0);
        chk("t6_async_busy", 32'(bus.busy), 32'h0);
        chk("t6_async_addr", bus.rom_addr, 32'h0);
        chk("t6_async_cnt", bus.fetch_cnt, 32'h0);
        chk("t6_async_pc", bus.if_pc, 32'h0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_idle_addr", bus.rom_addr, 32'h0);
        chk("t6_idle_cnt", bus.fetch_cnt, 32'h0);
        chk("t6_idle_busy", 32'(bus.busy), 32'h0);
        pulse_start();
        step();
        chk("t6_restart_cnt", bus.fetch_cnt, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle/multicycle MIPS lab core.
- Owns the program counter and drives the address port of the combinational instruction ROM (256 x 32, word index Addr[9:2]).
- Captures each fetched word and its PC into a small prefetch FIFO, then hands them to decode over a valid/ready handshake.
- Handles start, halt and branch/jump redirect (flush) sequencing.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, prefetch FIFO entries; power of two, legal values 2..8.
- PTR_W, $clog2(DEPTH), FIFO pointer width (derived; not overridden).

Ports:
- clk, input, 1, system clock; all state changes on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle pulse; IDLE/HALT -> RUN.
- halt_req, input, 1, stop issuing new fetches (level or pulse).
- redirect_valid, input, 1, branch taken or jump; flush and reload PC.
- redirect_pc, input, 32, new fetch address; bits [1:0] are ignored and forced to 0.
- rom_addr, output, 32, address to the instruction ROM; equals the PC register (combinational).
- rom_inst, input, 32, ROM data for rom_addr, valid in the same cycle.
- if_valid, output, 1, FIFO head holds an instruction.
- id_ready, input, 1, decode accepts the head this cycle.
- if_inst, output, 32, head instruction.
- if_pc, output, 32, head PC.
- busy, output, 1, state==RUN or FIFO non-empty.
- fetch_cnt, output, 32, number of pushes since reset; wraps.

Behaviour:
Reset (asynchronous assert, synchronous-safe deassert):
- pc=RESET_PC, state=IDLE, FIFO empty (count=0, rd/wr pointers=0), fetch_cnt=0.
- Outputs: if_valid=0, if_inst=0, if_pc=0, busy=0, rom_addr=RESET_PC.
- Reset mid-operation discards all FIFO contents and returns to IDLE.

States and transitions:
- IDLE: no push. start -> RUN.
- RUN: halt_req -> HALT. halt_req takes priority over start.
- HALT: no push. start (with halt_req low) -> RUN, resuming at the current pc.

Push (RUN only, no redirect this cycle):
- Push when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
- A push writes {pc, rom_inst}, then pc<=pc+4 and fetch_cnt<=fetch_cnt+1.
- There is no push in the cycle halt_req is sampled in RUN.

Pop:
- A pop occurs when if_valid && id_ready; the read pointer advances.
- if_inst/if_pc are driven combinationally from the FIFO head register. When empty they hold the last head value; they are don't-care when if_valid=0.

Simultaneous push and pop: count is unchanged and both pointers advance.

Redirect (any state):
- The FIFO is flushed (count=0, pointers equal) and pc<={redirect_pc[31:2],2'b00}.
- There is no push that cycle.
- A pop in the same cycle is considered accepted by decode; the flush discards the remaining entries.
- State is unchanged.

Boundary conditions:
- Full: count==DEPTH with no pop means no push and pc holds.
- Empty: if_valid=0.
- pc wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- fetch_cnt wraps at 2^32.
- Latency: ROM word at pc appears on if_inst one cycle after the push edge, i.e. if_valid rises the cycle after the first RUN cycle.
- Steady state with id_ready=1 gives throughput of 1 instruction/cycle.

Decomposition:
- A shared package, inst_fetch_pkg, holds:
  - fetch state enum (IDLE=2'd0, RUN=2'd1, HALT=2'd2);
  - RESET_PC default;
  - the entry struct {pc[31:0], inst[31:0]};
  - the MIPS opcode/funct constants already used by the ROM program, shared with decode.
- One natural sub-module, fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, full, empty and head. The controller instantiates it and keeps the PC/FSM logic.

Test Plan:
1. Reset, start pulse, id_ready=1, ROM program loaded -> if_pc/if_inst = 0x00/0x00000000, 0x04/0x00430820 (add $1,$2,$3), 0x08/0x00232022 (sub $4,$1,$3) on consecutive cycles; fetch_cnt=3 after 3 pushes.
2. RUN with id_ready=0 -> exactly DEPTH=2 entries pushed, rom_addr stalls at 0x08. Raise id_ready -> 0x00, 0x04, 0x08 delivered in order with no loss or duplicate.
3. redirect_valid with redirect_pc=0x0000_0013 while FIFO full -> next cycle if_valid=0, rom_addr=0x10. The following cycle delivers if_pc=0x10, if_inst=0x3426800A (ori $6,$1,0x800a).
4. halt_req at pc=0x0C -> state HALT, remaining entries drain, busy drops to 0. start -> fetch resumes at 0x0C.
5. Redirect to 0xFFFF_FFFC, then 2 pushes -> pcs 0xFFFF_FFFC, then 0x0000_0000 (wrap). rom_addr[9:2] = 8'hFF then 8'h00.
6. Assert rst_n=0 asynchronously mid-RUN with the FIFO holding 2 entries -> outputs go to reset values immediately without a clock edge. After release, state is IDLE and no push occurs until start.
